// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_pkg
// Brief    : AHB transfer/response encodings, data-phase states, slave indices.
// Revision : 1.0
// ============================================================================
package ahb_pkg;

   localparam logic [1:0] c_htrans_idle   = 2'b00;
   localparam logic [1:0] c_htrans_busy   = 2'b01;
   localparam logic [1:0] c_htrans_nonseq = 2'b10;
   localparam logic [1:0] c_htrans_seq    = 2'b11;

   localparam logic c_hresp_okay  = 1'b0;
   localparam logic c_hresp_error = 1'b1;

   // Select-bit positions, shared with the address decoder
   localparam int c_slv0_idx = 0;
   localparam int c_slv1_idx = 1;
   localparam int c_slv2_idx = 2;

   typedef enum logic [2:0] {
      DP_IDLE = 3'd0,
      DP_SLV0 = 3'd1,
      DP_SLV1 = 3'd2,
      DP_SLV2 = 3'd3,
      DP_ERR1 = 3'd4,
      DP_ERR2 = 3'd5
   } dp_state_t;

   function automatic logic trans_active(input logic [1:0] htrans);
      return (htrans == c_htrans_nonseq) || (htrans == c_htrans_seq);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_default_slave.sv
`default_nettype none
// ============================================================================
// Module   : ahb_default_slave
// Brief    : Answers unmapped transfers with a two-cycle ERROR, OKAY otherwise.
// Revision : 1.0
// ============================================================================
module ahb_default_slave
   import ahb_pkg::*;
(
   input  logic       HCLK,
   input  logic       HRESETn,
   input  logic       HSEL,
   input  logic [1:0] HTRANS,
   input  logic       HREADY,
   output logic       HREADYOUT,
   output logic       HRESP
);

   dp_state_t r_state;
   dp_state_t w_next;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) r_state <= DP_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      HREADYOUT = 1'b1;
      HRESP     = c_hresp_okay;
      case (r_state)
         DP_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = c_hresp_error;
         end
         DP_ERR2: HRESP = c_hresp_error;
         default: ;
      endcase
      // ERR1 stalls the bus, so it must advance on its own
      if (r_state == DP_ERR1)
         w_next = DP_ERR2;
      else if (HREADY)
         w_next = (HSEL && trans_active(HTRANS)) ? DP_ERR1 : DP_IDLE;
   end

endmodule
`default_nettype wire

// File: rtl/ahb_slave_mux.sv
`default_nettype none
// ============================================================================
// Module   : ahb_slave_mux
// Brief    : AHB read-data/ready/response mux for three slaves plus default slave.
// Revision : 1.0
// ============================================================================
module ahb_slave_mux
   import ahb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_SLAVES = 3
)(
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL0,
   input  logic                  HSEL1,
   input  logic                  HSEL2,
   input  logic [1:0]            HTRANS,
   input  logic [DATA_WIDTH-1:0] HRDATA0,
   input  logic [DATA_WIDTH-1:0] HRDATA1,
   input  logic [DATA_WIDTH-1:0] HRDATA2,
   input  logic                  HREADYOUT0,
   input  logic                  HREADYOUT1,
   input  logic                  HREADYOUT2,
   input  logic                  HRESP0,
   input  logic                  HRESP1,
   input  logic                  HRESP2,
   output logic [DATA_WIDTH-1:0] HRDATA,
   output logic                  HREADY,
   output logic                  HRESP
);

   logic [NUM_SLAVES-1:0] w_hsel;
   logic                  w_def_hreadyout;
   logic                  w_def_hresp;
   dp_state_t             r_state;
   dp_state_t             w_next;

   assign w_hsel = {HSEL2, HSEL1, HSEL0};

   ahb_default_slave u_default_slave (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .HSEL      (~|w_hsel),
      .HTRANS    (HTRANS),
      .HREADY    (HREADY),
      .HREADYOUT (w_def_hreadyout),
      .HRESP     (w_def_hresp)
   );

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) r_state <= DP_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      HRDATA = '0;
      HREADY = w_def_hreadyout;
      HRESP  = w_def_hresp;
      w_next = r_state;
      case (r_state)
         DP_SLV0: begin
            HRDATA = HRDATA0;
            HREADY = HREADYOUT0;
            HRESP  = HRESP0;
         end
         DP_SLV1: begin
            HRDATA = HRDATA1;
            HREADY = HREADYOUT1;
            HRESP  = HRESP1;
         end
         DP_SLV2: begin
            HRDATA = HRDATA2;
            HREADY = HREADYOUT2;
            HRESP  = HRESP2;
         end
         default: ;
      endcase
      // Lowest select index wins if the decoder ever drives more than one
      if (r_state == DP_ERR1)
         w_next = DP_ERR2;
      else if (HREADY) begin
         if      (w_hsel[c_slv0_idx]) w_next = DP_SLV0;
         else if (w_hsel[c_slv1_idx]) w_next = DP_SLV1;
         else if (w_hsel[c_slv2_idx]) w_next = DP_SLV2;
         else if (trans_active(HTRANS)) w_next = DP_ERR1;
         else                         w_next = DP_IDLE;
      end
   end

endmodule
`default_nettype wire

// File: doc/ahb_slave_mux.md
AHB_SLAVE_MUX -- requirements
Module: ahb_slave_mux

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the width of every read-data bus.
REQ-002 Parameter NUM_SLAVES, default 3, fixed at 3 for this revision.
REQ-003 HCLK  input  1  bus clock; all state changes on its rising edge.
REQ-004 HRESETn  input  1  reset; asynchronous assert, active-low.
REQ-005 HSEL0/HSEL1/HSEL2  input  1 each  address-phase one-hot slave selects from the address decoder; all-zero means unmapped.
REQ-006 HTRANS  input  2  address-phase transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-007 HRDATA0/1/2  input  DATA_WIDTH each  slave read data.
REQ-008 HREADYOUT0/1/2  input  1 each  slave ready.
REQ-009 HRESP0/1/2  input  1 each  slave response: 0=OKAY, 1=ERROR.
REQ-010 HRDATA  output  DATA_WIDTH  read data returned to the master.
REQ-011 HREADY  output  1  bus ready, returned to the master and broadcast to all slaves.
REQ-012 HRESP  output  1  response returned to the master.

Function
REQ-013 Address phase is sampled only in cycles where HREADY=1; with HREADY=0 the data-phase state shall hold unchanged.
REQ-014 Data-phase state is one of DP_IDLE, DP_SLV0, DP_SLV1, DP_SLV2, DP_ERR1, DP_ERR2.
REQ-015 At an HREADY=1 edge: if HSELn=1, next state is DP_SLVn, regardless of HTRANS, because the slave handles IDLE itself.
REQ-016 At an HREADY=1 edge: if no select is set and HTRANS is NONSEQ or SEQ, next state is DP_ERR1.
REQ-017 At an HREADY=1 edge: if no select is set and HTRANS is IDLE or BUSY, next state is DP_IDLE.
REQ-018 DP_SLVn: HRDATA=HRDATAn, HREADY=HREADYOUTn and HRESP=HRESPn, driven combinationally with zero added latency.
REQ-019 DP_IDLE: HRDATA=0, HREADY=1, HRESP=0.
REQ-020 DP_ERR1: HRDATA=0, HREADY=0, HRESP=1; next state is DP_ERR2 unconditionally.
REQ-021 DP_ERR2: HRDATA=0, HREADY=1, HRESP=1; next state follows REQ-015..017 using the address phase present in that cycle.
REQ-022 In DP_ERR1, the address phase presented is not sampled, because HREADY=0.
REQ-023 If more than one HSEL is set, the lowest index wins; this is an illegal input and a bench assertion shall flag it.
REQ-024 Back-to-back transfers to different slaves switch the selection at the edge that completes the previous data phase, with no bubble cycle.
REQ-025 A slave error (HRESPn=1) is passed through unchanged; the mux does not generate or stretch slave responses.

Reset
REQ-026 While HRESETn=0, state is DP_IDLE and outputs are HRDATA=0, HREADY=1, HRESP=0, asynchronously.
REQ-027 Reset asserted mid-transfer, including in DP_ERR1, abandons the transfer; the first sampled address phase after release behaves per REQ-015..017.

Structure
REQ-028 Package ahb_pkg holds the HTRANS encodings and HRESP encodings.
REQ-029 Package ahb_pkg holds the data-phase state enum.
REQ-030 Package ahb_pkg holds the slave-index constants shared with the decoder.
REQ-031 The unmapped-address error generator (DP_IDLE/DP_ERR1/DP_ERR2 behaviour) is a sub-module named ahb_default_slave, exposing HREADYOUT/HRESP like a normal slave.

Verification
REQ-032 Scenario: HSEL1=1, NONSEQ; next cycle HRDATA1=0xA5A5_0001, HREADYOUT1=1 -> HRDATA=0xA5A5_0001, HREADY=1, HRESP=0 in that cycle.
REQ-033 Scenario: HSEL0 with HREADYOUT0 low for 3 cycles, next address phase HSEL2 -> HREADY=0 for 3 cycles, state held; DP_SLV2 entered only at the first HREADY=1 edge.
REQ-034 Scenario: no HSEL, NONSEQ -> HREADY=0/HRESP=1 for one cycle, then HREADY=1/HRESP=1 for one cycle, then DP_IDLE with OKAY.
REQ-035 Scenario: no HSEL, HTRANS=IDLE -> HREADY=1, HRESP=0, HRDATA=0 next cycle.
REQ-036 Scenario: error sequence back-to-back with NONSEQ to HSEL2 sampled in DP_ERR2 -> the next cycle returns HRDATA2/HREADYOUT2.
REQ-037 Scenario: HRESETn dropped in DP_ERR1 -> HREADY=1 and HRESP=0 immediately, without waiting for a clock edge.
